// File: rtl/y86_pkg.sv
// Shared constants and types for the Y86-64 multi-cycle sequencer.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
    S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam int SE_FETCH     = 0;
  localparam int SE_DECODE    = 1;
  localparam int SE_EXECUTE   = 2;
  localparam int SE_MEMORY    = 3;
  localparam int SE_WRITEBACK = 4;

endpackage

// File: rtl/y86_seq_controller_if.sv
// Bundle between the sequencer (master) and the surrounding datapath (slave).
interface y86_seq_controller_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              run;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic              instr_valid;
  logic              imem_error;
  logic [ADDR_W-1:0] valC;
  logic [ADDR_W-1:0] valP;
  logic [ADDR_W-1:0] valM;
  logic              zf, sf, of;
  logic              dmem_ack;
  logic              dmem_error;
  logic [ADDR_W-1:0] pc;
  logic [4:0]        stage_en;
  logic              dmem_req;
  logic              cnd;
  logic [1:0]        status;
  logic              retired;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  instr_cnt;

  modport master (
    input  run, icode, ifun, instr_valid, imem_error, valC, valP, valM,
           zf, sf, of, dmem_ack, dmem_error,
    output pc, stage_en, dmem_req, cnd, status, retired, cycle_cnt, instr_cnt
  );

  modport slave (
    output run, icode, ifun, instr_valid, imem_error, valC, valP, valM,
           zf, sf, of, dmem_ack, dmem_error,
    input  pc, stage_en, dmem_req, cnd, status, retired, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/y86_cond_eval.sv
// Combinational Y86 condition evaluation for jXX and cmovXX.
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] i_ifun,
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  output logic       o_cnd
);
  logic w_lt;
  assign w_lt = i_sf ^ i_of;

  always_comb begin
    o_cnd = 1'b0;
    case (i_ifun)
      C_ALWAYS: o_cnd = 1'b1;
      C_LE:     o_cnd = w_lt | i_zf;
      C_L:      o_cnd = w_lt;
      C_E:      o_cnd = i_zf;
      C_NE:     o_cnd = ~i_zf;
      C_GE:     o_cnd = ~w_lt;
      C_G:      o_cnd = ~w_lt & ~i_zf;
      default:  o_cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle Y86-64 sequencer: stage enables, PC ownership, memory handshake,
// sticky status, run/step control and saturating performance counters.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 16,
  parameter int                CNT_W       = 32
) (
  input logic                  clk,
  input logic                  reset,
  y86_seq_controller_if.master io_bus
);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state, w_nextState;
  logic [1:0]        r_status, w_nextStatus;
  logic [ADDR_W-1:0] r_pc, r_valM, w_nextPc;
  logic [4:0]        r_stageEn, w_stageEn;
  logic [TMO_W-1:0]  r_memCnt;
  logic [CNT_W-1:0]  r_cycleCnt, r_instrCnt;
  logic              r_cnd, r_dmemReq, r_retired;
  logic              w_retire, w_ackTake, w_condRaw, w_isCondOp, w_needsMem, w_badInstr;

  y86_cond_eval u_cond (
    .i_ifun (io_bus.ifun),
    .i_zf   (io_bus.zf),
    .i_sf   (io_bus.sf),
    .i_of   (io_bus.of),
    .o_cnd  (w_condRaw)
  );

  assign w_isCondOp = (io_bus.icode == I_CMOVXX) || (io_bus.icode == I_JXX);
  assign w_needsMem = io_bus.icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  assign w_badInstr = !io_bus.instr_valid || (io_bus.icode > I_POPQ) ||
                      (w_isCondOp && (io_bus.ifun > C_G));

  always_comb begin
    w_nextState  = r_state;
    w_nextStatus = r_status;
    w_retire     = 1'b0;
    w_ackTake    = 1'b0;
    case (r_state)
      S_IDLE:    if (io_bus.run) w_nextState = S_FETCH;
      S_FETCH: begin
        if (io_bus.imem_error) begin
          w_nextStatus = STAT_ADR;
          w_nextState  = S_HALTED;
        end else begin
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_badInstr) begin
          w_nextStatus = STAT_INS;
          w_nextState  = S_HALTED;
        end else if (io_bus.icode == I_HALT) begin
          w_nextStatus = STAT_HLT;
          w_nextState  = S_HALTED;
          w_retire     = 1'b1;
        end else begin
          w_nextState = S_EXECUTE;
        end
      end
      S_EXECUTE: w_nextState = w_needsMem ? S_MEMORY : S_WRITEBACK;
      // Error outranks ack; silence for MEM_TIMEOUT cycles is treated as an address fault
      S_MEMORY: begin
        if (io_bus.dmem_error) begin
          w_nextStatus = STAT_ADR;
          w_nextState  = S_HALTED;
        end else if (io_bus.dmem_ack) begin
          w_ackTake   = 1'b1;
          w_nextState = S_WRITEBACK;
        end else if (r_memCnt == TMO_W'(MEM_TIMEOUT - 1)) begin
          w_nextStatus = STAT_ADR;
          w_nextState  = S_HALTED;
        end
      end
      S_WRITEBACK: w_nextState = S_PCUPD;
      S_PCUPD: begin
        w_retire    = 1'b1;
        w_nextState = io_bus.run ? S_FETCH : S_IDLE;
      end
      S_HALTED: w_nextState = S_HALTED;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_stageEn               = '0;
    w_stageEn[SE_FETCH]     = (w_nextState == S_FETCH);
    w_stageEn[SE_DECODE]    = (w_nextState == S_DECODE);
    w_stageEn[SE_EXECUTE]   = (w_nextState == S_EXECUTE);
    w_stageEn[SE_MEMORY]    = (w_nextState == S_MEMORY);
    w_stageEn[SE_WRITEBACK] = (w_nextState == S_WRITEBACK);
  end

  always_comb begin
    w_nextPc = io_bus.valP;
    if ((io_bus.icode == I_CALL) || ((io_bus.icode == I_JXX) && r_cnd))
      w_nextPc = io_bus.valC;
    else if (io_bus.icode == I_RET)
      w_nextPc = r_valM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_status   <= STAT_AOK;
      r_pc       <= RESET_PC;
      r_valM     <= '0;
      r_cnd      <= 1'b0;
      r_stageEn  <= '0;
      r_dmemReq  <= 1'b0;
      r_retired  <= 1'b0;
      r_memCnt   <= '0;
      r_cycleCnt <= '0;
      r_instrCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_status  <= w_nextStatus;
      r_stageEn <= w_stageEn;
      r_dmemReq <= (w_nextState == S_MEMORY);
      r_retired <= w_retire;
      r_memCnt  <= (r_state == S_MEMORY) ? r_memCnt + 1'b1 : '0;
      if (r_state == S_EXECUTE)
        r_cnd <= w_isCondOp & w_condRaw;
      if (w_ackTake)
        r_valM <= io_bus.valM;
      if (r_state == S_PCUPD)
        r_pc <= w_nextPc;
      if (w_retire && (r_instrCnt != {CNT_W{1'b1}}))
        r_instrCnt <= r_instrCnt + 1'b1;
      if ((r_state != S_IDLE) && (r_state != S_HALTED) && (r_cycleCnt != {CNT_W{1'b1}}))
        r_cycleCnt <= r_cycleCnt + 1'b1;
    end
  end

  assign io_bus.pc        = r_pc;
  assign io_bus.stage_en  = r_stageEn;
  assign io_bus.dmem_req  = r_dmemReq;
  assign io_bus.cnd       = r_cnd;
  assign io_bus.status    = r_status;
  assign io_bus.retired   = r_retired;
  assign io_bus.cycle_cnt = r_cycleCnt;
  assign io_bus.instr_cnt = r_instrCnt;
endmodule
